// File: rtl/arp_rx_parser.sv
// ARP receive parser: validates the fixed header, filters on target IP and hands one parsed
// request per frame to the reply generator. Optional macro ARP_RX_ACCEPT_REPLY_EN also accepts OPER=2.
module arp_rx_parser #(
  parameter int unsigned CNT_WIDTH       = 16,
  parameter int unsigned MAX_FRAME_BYTES = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          local_ip,
  input  logic [7:0]           axis_tdata_in,
  input  logic                 axis_tvalid_in,
  input  logic                 axis_tlast_in,
  output logic                 axis_tready_o,
  output logic                 req_valid_o,
  input  logic                 req_ready_i,
  output logic [15:0]          req_opcode_o,
  output logic [47:0]          req_sender_mac_o,
  output logic [31:0]          req_sender_ip_o,
  output logic                 drop_pulse_o,
  output logic [CNT_WIDTH-1:0] drop_cnt_o,
  output logic [CNT_WIDTH-1:0] ovf_cnt_o
);

  localparam int unsigned BcW = $clog2(MAX_FRAME_BYTES + 1);

  typedef enum logic [1:0] {StIdle, StParse, StDiscard, StCommit} state_e;

  state_e               state_q, state_d;
  logic [BcW-1:0]       byte_cnt_q, byte_cnt_d;
  logic                 bad_q, bad_d;
  logic [15:0]          oper_sh_q, oper_sh_d;
  logic [47:0]          sha_sh_q, sha_sh_d;
  logic [31:0]          spa_sh_q, spa_sh_d;
  logic [23:0]          tpa_sh_q, tpa_sh_d;
  logic                 req_valid_q, req_valid_d;
  logic [15:0]          req_opcode_q, req_opcode_d;
  logic [47:0]          req_mac_q, req_mac_d;
  logic [31:0]          req_ip_q, req_ip_d;
  logic                 drop_pulse_q, drop_pulse_d;
  logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_WIDTH-1:0] ovf_cnt_q, ovf_cnt_d;

  int   offset;
  logic hdr_ok;
  logic reject;

  // In IDLE the arriving beat is offset 0; in PARSE byte_cnt already points at the current beat.
  assign offset = (state_q == StIdle) ? 0 : int'(byte_cnt_q);

  always_comb begin
    hdr_ok = 1'b1;
    case (offset)
      0:  hdr_ok = (axis_tdata_in == 8'h00);
      1:  hdr_ok = (axis_tdata_in == 8'h01);
      2:  hdr_ok = (axis_tdata_in == 8'h08);
      3:  hdr_ok = (axis_tdata_in == 8'h00);
      4:  hdr_ok = (axis_tdata_in == 8'h06);
      5:  hdr_ok = (axis_tdata_in == 8'h04);
      6:  hdr_ok = (axis_tdata_in == 8'h00);
`ifdef ARP_RX_ACCEPT_REPLY_EN
      7:  hdr_ok = (axis_tdata_in == 8'h01) || (axis_tdata_in == 8'h02);
`else
      7:  hdr_ok = (axis_tdata_in == 8'h01);
`endif
      27: hdr_ok = ({tpa_sh_q, axis_tdata_in} == local_ip);
      default: hdr_ok = 1'b1;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    bad_d        = bad_q;
    oper_sh_d    = oper_sh_q;
    sha_sh_d     = sha_sh_q;
    spa_sh_d     = spa_sh_q;
    tpa_sh_d     = tpa_sh_q;
    req_valid_d  = req_valid_q;
    req_opcode_d = req_opcode_q;
    req_mac_d    = req_mac_q;
    req_ip_d     = req_ip_q;
    drop_pulse_d = 1'b0;
    drop_cnt_d   = drop_cnt_q;
    ovf_cnt_d    = ovf_cnt_q;
    reject       = 1'b0;

    if (req_valid_q && req_ready_i) req_valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (axis_tvalid_in) begin
          byte_cnt_d = BcW'(1);
          bad_d      = 1'b0;
          if (axis_tlast_in) begin
            reject = 1'b1;
          end else if (!hdr_ok) begin
            bad_d   = 1'b1;
            state_d = StDiscard;
          end else begin
            state_d = StParse;
          end
        end
      end
      StParse: begin
        if (axis_tvalid_in) begin
          byte_cnt_d = byte_cnt_q + BcW'(1);
          if (offset >= 6 && offset <= 7)   oper_sh_d = {oper_sh_q[7:0], axis_tdata_in};
          if (offset >= 8 && offset <= 13)  sha_sh_d  = {sha_sh_q[39:0], axis_tdata_in};
          if (offset >= 14 && offset <= 17) spa_sh_d  = {spa_sh_q[23:0], axis_tdata_in};
          if (offset >= 24 && offset <= 26) tpa_sh_d  = {tpa_sh_q[15:0], axis_tdata_in};
          if (offset == 27) begin
            if (!hdr_ok) begin
              if (axis_tlast_in) begin
                reject = 1'b1;
              end else begin
                bad_d   = 1'b1;
                state_d = StDiscard;
              end
            end else begin
              state_d = axis_tlast_in ? StCommit : StDiscard;
            end
          end else if (axis_tlast_in) begin
            reject = 1'b1;
          end else if (!hdr_ok) begin
            bad_d   = 1'b1;
            state_d = StDiscard;
          end
        end
      end
      StDiscard: begin
        if (axis_tvalid_in) begin
          if (int'(byte_cnt_q) < int'(MAX_FRAME_BYTES)) byte_cnt_d = byte_cnt_q + BcW'(1);
          if (axis_tlast_in) begin
            if (bad_q) reject = 1'b1;
            else       state_d = StCommit;
          end else if (int'(byte_cnt_q) + 1 >= int'(MAX_FRAME_BYTES)) begin
            bad_d = 1'b1;
          end
        end
      end
      StCommit: begin
        // A handshake this cycle frees the slot for the new request.
        if (!req_valid_q || req_ready_i) begin
          req_valid_d  = 1'b1;
          req_opcode_d = oper_sh_q;
          req_mac_d    = sha_sh_q;
          req_ip_d     = spa_sh_q;
        end else if (!(&ovf_cnt_q)) begin
          ovf_cnt_d = ovf_cnt_q + CNT_WIDTH'(1);
        end
        state_d = StIdle;
      end
    endcase

    if (reject) begin
      drop_pulse_d = 1'b1;
      if (!(&drop_cnt_q)) drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      byte_cnt_q   <= '0;
      bad_q        <= 1'b0;
      oper_sh_q    <= '0;
      sha_sh_q     <= '0;
      spa_sh_q     <= '0;
      tpa_sh_q     <= '0;
      req_valid_q  <= 1'b0;
      req_opcode_q <= '0;
      req_mac_q    <= '0;
      req_ip_q     <= '0;
      drop_pulse_q <= 1'b0;
      drop_cnt_q   <= '0;
      ovf_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      bad_q        <= bad_d;
      oper_sh_q    <= oper_sh_d;
      sha_sh_q     <= sha_sh_d;
      spa_sh_q     <= spa_sh_d;
      tpa_sh_q     <= tpa_sh_d;
      req_valid_q  <= req_valid_d;
      req_opcode_q <= req_opcode_d;
      req_mac_q    <= req_mac_d;
      req_ip_q     <= req_ip_d;
      drop_pulse_q <= drop_pulse_d;
      drop_cnt_q   <= drop_cnt_d;
      ovf_cnt_q    <= ovf_cnt_d;
    end
  end

  assign axis_tready_o    = 1'b1;
  assign req_valid_o      = req_valid_q;
  assign req_opcode_o     = req_opcode_q;
  assign req_sender_mac_o = req_mac_q;
  assign req_sender_ip_o  = req_ip_q;
  assign drop_pulse_o     = drop_pulse_q;
  assign drop_cnt_o       = drop_cnt_q;
  assign ovf_cnt_o        = ovf_cnt_q;

endmodule

// File: tb/tb_arp_rx_parser.sv
// Directed bench for arp_rx_parser: a table of frame vectors plus hand-written sequences
// for backpressure, same-cycle handshake and mid-frame reset.
module tb_arp_rx_parser;

  localparam logic [31:0] LocalIp = 32'hC0A8_0180;
  localparam logic [47:0] Sha     = 48'h000A_3501_0203;
  localparam logic [31:0] SpaA    = 32'hC0A8_010A;
  localparam logic [31:0] SpaB    = 32'hC0A8_010B;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] local_ip;
  logic [7:0]  axis_tdata_in;
  logic        axis_tvalid_in;
  logic        axis_tlast_in;
  logic        axis_tready_o;
  logic        req_valid_o;
  logic        req_ready_i;
  logic [15:0] req_opcode_o;
  logic [47:0] req_sender_mac_o;
  logic [31:0] req_sender_ip_o;
  logic        drop_pulse_o;
  logic [15:0] drop_cnt_o;
  logic [15:0] ovf_cnt_o;

  always #5 clk = ~clk;

  arp_rx_parser dut (
    .clk              (clk),
    .reset            (reset),
    .local_ip         (local_ip),
    .axis_tdata_in    (axis_tdata_in),
    .axis_tvalid_in   (axis_tvalid_in),
    .axis_tlast_in    (axis_tlast_in),
    .axis_tready_o    (axis_tready_o),
    .req_valid_o      (req_valid_o),
    .req_ready_i      (req_ready_i),
    .req_opcode_o     (req_opcode_o),
    .req_sender_mac_o (req_sender_mac_o),
    .req_sender_ip_o  (req_sender_ip_o),
    .drop_pulse_o     (drop_pulse_o),
    .drop_cnt_o       (drop_cnt_o),
    .ovf_cnt_o        (ovf_cnt_o)
  );

  typedef struct {
    int          len;
    logic [15:0] ptype;
    logic [15:0] oper;
    logic [31:0] spa;
    logic [31:0] tpa;
    bit          exp_req;
  } vec_t;

  vec_t        vecs[9];
  logic [7:0]  frame[0:79];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          exp_drop = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic build(input vec_t v);
    for (int i = 0; i < 80; i++) frame[i] = 8'h00;
    frame[0] = 8'h00;        frame[1] = 8'h01;
    frame[2] = v.ptype[15:8]; frame[3] = v.ptype[7:0];
    frame[4] = 8'h06;        frame[5] = 8'h04;
    frame[6] = v.oper[15:8]; frame[7] = v.oper[7:0];
    for (int i = 0; i < 6; i++) frame[8 + i]  = Sha[47 - 8*i -: 8];
    for (int i = 0; i < 4; i++) frame[14 + i] = v.spa[31 - 8*i -: 8];
    for (int i = 0; i < 4; i++) frame[24 + i] = v.tpa[31 - 8*i -: 8];
  endtask

  task automatic send(input int len, input bit with_last);
    for (int i = 0; i < len; i++) begin
      axis_tdata_in  = frame[i];
      axis_tvalid_in = 1'b1;
      axis_tlast_in  = with_last && (i == len - 1);
      step();
    end
    axis_tvalid_in = 1'b0;
    axis_tlast_in  = 1'b0;
  endtask

  function automatic vec_t good(input int len, input logic [31:0] spa);
    vec_t v;
    v = '{len, 16'h0800, 16'h0001, spa, LocalIp, 1'b1};
    return v;
  endfunction

  task automatic check_req(input string tag, input logic [15:0] op, input logic [31:0] spa);
    check({tag, " req_valid"}, 64'(req_valid_o), 64'd1);
    check({tag, " opcode"}, 64'(req_opcode_o), 64'(op));
    check({tag, " mac"}, 64'(req_sender_mac_o), 64'(Sha));
    check({tag, " ip"}, 64'(req_sender_ip_o), 64'(spa));
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    build(v);
    send(v.len, 1'b1);
    if (v.exp_req) begin
      check({tag, " no_drop_pulse"}, 64'(drop_pulse_o), 64'd0);
      check({tag, " not_yet_valid"}, 64'(req_valid_o), 64'd0);
      step();
      check_req(tag, v.oper, v.spa);
      step();
      check({tag, " valid_cleared"}, 64'(req_valid_o), 64'd0);
    end else begin
      exp_drop++;
      check({tag, " drop_pulse"}, 64'(drop_pulse_o), 64'd1);
      step();
      check({tag, " drop_pulse_end"}, 64'(drop_pulse_o), 64'd0);
      check({tag, " no_req"}, 64'(req_valid_o), 64'd0);
    end
    check({tag, " drop_cnt"}, 64'(drop_cnt_o), 64'(exp_drop));
    check({tag, " ovf_cnt"}, 64'(ovf_cnt_o), 64'd0);
  endtask

  initial begin
    vec_t v;
    vecs[0] = good(28, SpaA);
    vecs[1] = good(46, SpaA);
    vecs[2] = good(28, SpaA); vecs[2].tpa = 32'hC0A8_0181; vecs[2].exp_req = 1'b0;
    vecs[3] = good(28, SpaA); vecs[3].ptype = 16'h86DD;    vecs[3].exp_req = 1'b0;
    vecs[4] = good(21, SpaA); vecs[4].exp_req = 1'b0;
    vecs[5] = good(28, SpaB);
    vecs[6] = good(28, SpaA); vecs[6].oper = 16'h0002;
`ifdef ARP_RX_ACCEPT_REPLY_EN
    vecs[6].exp_req = 1'b1;
`else
    vecs[6].exp_req = 1'b0;
`endif
    vecs[7] = good(70, SpaA); vecs[7].exp_req = 1'b0;
    vecs[8] = good(64, SpaB);

    reset          = 1'b1;
    local_ip       = LocalIp;
    axis_tdata_in  = 8'h00;
    axis_tvalid_in = 1'b0;
    axis_tlast_in  = 1'b0;
    req_ready_i    = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();

    check("reset req_valid", 64'(req_valid_o), 64'd0);
    check("reset opcode", 64'(req_opcode_o), 64'd0);
    check("reset drop_pulse", 64'(drop_pulse_o), 64'd0);
    check("reset drop_cnt", 64'(drop_cnt_o), 64'd0);
    check("reset ovf_cnt", 64'(ovf_cnt_o), 64'd0);
    check("tready", 64'(axis_tready_o), 64'd1);

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Back-to-back good frames with the consumer stalled.
    req_ready_i = 1'b0;
    v = good(28, SpaA); build(v); send(28, 1'b1); step();
    check_req("bp first", 16'h0001, SpaA);
    v = good(28, SpaB); build(v); send(28, 1'b1);
    check_req("bp held_commit", 16'h0001, SpaA);
    step();
    check_req("bp held_after", 16'h0001, SpaA);
    check("bp ovf_cnt", 64'(ovf_cnt_o), 64'd1);
    req_ready_i = 1'b1;
    step();
    check("bp valid_cleared", 64'(req_valid_o), 64'd0);

    // Handshake lands on the COMMIT cycle: new request loads, no overflow.
    req_ready_i = 1'b0;
    v = good(28, SpaA); build(v); send(28, 1'b1); step();
    check_req("hs first", 16'h0001, SpaA);
    v = good(28, SpaB); build(v); send(28, 1'b1);
    req_ready_i = 1'b1;
    step();
    check_req("hs second", 16'h0001, SpaB);
    check("hs ovf_cnt", 64'(ovf_cnt_o), 64'd1);
    step();
    check("hs valid_cleared", 64'(req_valid_o), 64'd0);

    // Reset mid-frame while a request is held.
    req_ready_i = 1'b0;
    v = good(28, SpaA); build(v); send(28, 1'b1); step();
    check("rst held", 64'(req_valid_o), 64'd1);
    send(11, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst req_valid", 64'(req_valid_o), 64'd0);
    check("rst opcode", 64'(req_opcode_o), 64'd0);
    check("rst mac", 64'(req_sender_mac_o), 64'd0);
    check("rst ip", 64'(req_sender_ip_o), 64'd0);
    check("rst drop_pulse", 64'(drop_pulse_o), 64'd0);
    check("rst drop_cnt", 64'(drop_cnt_o), 64'd0);
    check("rst ovf_cnt", 64'(ovf_cnt_o), 64'd0);
    req_ready_i = 1'b1;
    exp_drop    = 0;
    run_vec(99, good(28, SpaB));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arp_rx_parser.md
Name: arp_rx_parser

Overview:
- Sits directly downstream of the receive buffer's ARP output stream. Consumes the 8-bit ARP payload stream, which begins at the HTYPE byte.
- Validates the fixed ARP header fields and extracts OPER, SHA, SPA and TPA. Filters on target IP equal to the local IP.
- Presents one parsed request per frame on a valid/ready handshake to the ARP reply generator. Counts dropped and overflowed frames for debug.

Parameters:
- CNT_WIDTH, 16, width of the drop and overflow counters (saturating).
- MAX_FRAME_BYTES, 64, beat limit per frame; beyond this the frame is dropped.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- local_ip  in  32  this node's IPv4 address, compared against TPA
- axis_tdata_in  in  8  ARP byte stream
- axis_tvalid_in  in  1  beat valid
- axis_tlast_in  in  1  last beat of frame
- axis_tready_o  out  1  tied to 1; upstream ignores backpressure
- req_valid_o  out  1  parsed request available
- req_ready_i  in  1  consumer accepts request
- req_opcode_o  out  16  OPER field
- req_sender_mac_o  out  48  SHA
- req_sender_ip_o  out  32  SPA
- drop_pulse_o  out  1  one-cycle pulse when a frame is rejected
- drop_cnt_o  out  CNT_WIDTH  rejected frames, saturating
- ovf_cnt_o  out  CNT_WIDTH  valid requests lost because the output slot was busy, saturating

Behaviour:
- Reset values: req_valid_o=0, all req_* fields=0, drop_pulse_o=0, both counters=0, state=IDLE, byte_cnt=0.
- Byte offsets within a frame:
  - 0-1 HTYPE, must be 0x0001
  - 2-3 PTYPE, must be 0x0800
  - 4 HLEN, must be 6
  - 5 PLEN, must be 4
  - 6-7 OPER, must be 0x0001
  - 8-13 SHA
  - 14-17 SPA
  - 18-23 THA, ignored
  - 24-27 TPA, must equal local_ip
  - 28.. padding, discarded
- Fields are shifted MSB-first into shadow registers on each beat where axis_tvalid_in=1. byte_cnt increments only on valid beats.
- States:
  - IDLE: first valid beat moves to PARSE with byte_cnt=1; that byte is checked as offset 0.
  - PARSE: any header mismatch sets a sticky bad flag and moves to DISCARD, unless the mismatching beat carries tlast.
    - tlast with byte_cnt<27 (frame shorter than 28 bytes): reject.
    - byte 27 without tlast: move to DISCARD with good status (padding follows).
    - byte 27 with tlast: move to COMMIT.
  - DISCARD: consume beats until tlast, then COMMIT if status good, otherwise reject. Reaching MAX_FRAME_BYTES without tlast sets bad and keeps discarding.
  - COMMIT: single cycle, no input beat is consumed. If the output slot is free, copy shadows to req_* and assert req_valid_o. Otherwise increment ovf_cnt_o. Then return to IDLE.
- Reject path: drop_pulse_o=1 for exactly one cycle in the cycle after the tlast beat. drop_cnt_o increments. State returns to IDLE.
- Latency: req_valid_o rises 2 cycles after the tlast beat is sampled (tlast beat → COMMIT → registered output).
- Handshake:
  - req_valid_o holds, with req_* stable, until req_valid_o&&req_ready_i.
  - It clears on the cycle after the handshake.
  - A handshake in the same cycle as COMMIT frees the slot, so the new request loads and no overflow is counted.
- A valid beat arriving during COMMIT is dropped. This is not expected, since upstream inserts an END gap. It is also not counted.
- A new frame may begin parsing while req_valid_o is held. Output registers stay untouched until COMMIT.
- Counters saturate at all-ones.
- Reset asserted mid-frame or while req_valid_o is held clears everything. The partial frame is not counted.
- local_ip is sampled at the byte-27 beat.

Optional Feature:
- Macro ARP_RX_ACCEPT_REPLY_EN.
- Defined:
  - OPER 0x0002 is also accepted.
  - TPA must still match.
  - req_opcode_o distinguishes request from reply, so the consumer can learn the peer's MAC.
- Undefined:
  - Only OPER 0x0001 is accepted.
  - OPER 0x0002 is rejected like any other bad opcode, incrementing drop_cnt_o.

Test Plan:
- Valid 28-byte request: SHA=00:0A:35:01:02:03, SPA=192.168.1.10, TPA=192.168.1.128=local_ip, tlast on byte 27, req_ready_i=1 → req_valid_o 2 cycles after tlast for one cycle; opcode=0x0001, mac=0x000A35010203, ip=0xC0A8010A; drop_cnt_o=0.
- Same frame padded to 46 bytes, tlast on byte 45 → identical request 2 cycles after byte-45 tlast; no drop.
- TPA=192.168.1.129 → no req_valid_o; drop_pulse_o one cycle; drop_cnt_o=1. Repeat with PTYPE=0x86DD → drop_cnt_o=2.
- Short frame, tlast at byte 20 → drop_cnt_o=1. The next good frame is still parsed correctly (state recovery).
- req_ready_i=0 while two good frames arrive back-to-back → first request held stable; ovf_cnt_o=1. Raising req_ready_i clears req_valid_o next cycle.
- OPER=0x0002 good frame → with ARP_RX_ACCEPT_REPLY_EN, request with opcode 0x0002; without it, drop_cnt_o=1. Reset mid-frame at byte 10 → all outputs zero; counters 0.
